quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
- Upstream stage for counter_2bit.
- Takes two asynchronous quadrature inputs (A/B) from an encoder or switch pair, then synchronises, deglitches and decodes them.
- Produces a one-cycle step strobe plus a direction level that drive the counter's count-enable and up inputs.
- Flags illegal Gray-code transitions with a sticky error bit.

Parameters:
- FILT_LEN, 3: consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates. Legal range 1..15.
- UP_RST, 1: reset value of the up output.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- a_in  input  1  quadrature channel A, asynchronous to clk
- b_in  input  1  quadrature channel B, asynchronous to clk
- err_clr  input  1  synchronous clear of err
- step  output  1  one-cycle pulse per legal quadrature transition
- up  output  1  direction of the last legal step (1 = count up)
- err  output  1  sticky illegal-transition flag

Behaviour:
- Reset (rst=1, asynchronous) sets:
  - sync flops, filtered A/B, filter counters: 0
  - step: 0; up: UP_RST; err: 0
- Synchroniser: two flops per channel (s1, s2). s2 feeds the filter.
- Filter, per channel, independent, counter width ceil(log2(FILT_LEN+1)):
  - If s2 == filt: cnt <= 0.
  - Else if cnt == FILT_LEN-1: filt <= s2, cnt <= 0 (update event).
  - Else: cnt <= cnt+1.
  - Any single cycle of s2 == filt restarts the count, so glitches shorter than FILT_LEN cycles are rejected.
- Latency: the first edge sampling a new a_in level is edge 1. The filtered value and step both change at edge FILT_LEN+2 (edge 5 for the default).
- Decode, evaluated at each edge using old filtered {A,B} and next filtered {A,B}:
  - Forward sequence 00->01->11->10->00 (bit1=A, bit0=B): step <= 1, up <= 1.
  - Reverse sequence 00->10->11->01->00: step <= 1, up <= 0.
  - No change: step <= 0, up holds.
  - Both bits change on the same edge (00<->11 or 01<->10): illegal. step <= 0, up holds, err <= 1.
- step is high for exactly one cycle per update event. Back-to-back legal updates on consecutive edges give step high on consecutive cycles, each evaluated independently.
- A and B transitions one cycle apart at the pins produce two separate legal steps.
- err:
  - Set on an illegal transition; held until err_clr=1.
  - If err_clr and an illegal transition occur on the same edge, set wins (err stays 1).
- Reset mid-operation: all state returns to reset values immediately. Counts in progress are discarded. No step is emitted on reset deassertion, even if inputs are nonzero; the filter then converges from 00 by normal update events, which may produce steps or err.
- Outputs are registered with no combinational path from inputs.

Test Plan:
1. Reset release, a_in=b_in=0 held for 20 cycles -> step=0 every cycle, up=UP_RST=1, err=0.
2. Forward sequence 00->01->11->10->00, each level held 8 cycles, FILT_LEN=3 -> exactly 4 single-cycle step pulses. Each pulse starts 5 edges after the pin change. up=1 throughout, err=0.
3. Reverse sequence 00->10->11->01->00 -> 4 step pulses, up goes 0 with the first pulse and stays 0, err=0.
4. Glitch: a_in pulsed high for 2 cycles (FILT_LEN=3), then 0 -> no step, filtered A stays 0. A 3-cycle pulse -> exactly one step (up=0, since 00->10 is reverse), followed by one more step (up=1, since 10->00 is forward) on return.
5. Illegal transition: a_in and b_in toggled 0->1 on the same cycle -> err=1 at edge 5, no step, up unchanged.
   - err_clr=1 for one cycle -> err=0 next cycle.
   - Repeat with err_clr asserted on the same edge as the illegal update -> err remains 1.
6. Reset mid-filter: a_in=1 held for 3 cycles, then rst=1 for 1 cycle -> step never asserts, err=0. After release, with a_in still 1 -> step at edge FILT_LEN+2 after release, up=0.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronises and deglitches A/B, then decodes Gray-code
// transitions into a one-cycle step strobe, a direction level and a sticky error flag.
module quad_step_decoder #(
   parameter int unsigned FILT_LEN = 3,
   parameter bit          UP_RST   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic a_in,
   input  logic b_in,
   input  logic err_clr,
   output logic step,
   output logic up,
   output logic err
);

   localparam int unsigned CntW = $clog2(FILT_LEN + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN - 1);

   // Bit 1 carries channel A, bit 0 channel B throughout.
   logic [1:0]           s1_q, s1_d;
   logic [1:0]           s2_q, s2_d;
   logic [1:0]           filt_q, filt_d;
   logic [1:0][CntW-1:0] cnt_q, cnt_d;
   logic                 step_q, step_d;
   logic                 up_q, up_d;
   logic                 err_q, err_d;
   logic [1:0]           diff;

   always_comb begin
      s1_d = {a_in, b_in};
      s2_d = s1_q;
   end

   // Any cycle where s2 agrees with the filtered value restarts the run count.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] != filt_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               filt_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      diff   = filt_q ^ filt_d;
      step_d = 1'b0;
      up_d   = up_q;
      err_d  = err_q & ~err_clr;
      unique case (diff)
         2'b00: begin
         end
         2'b11: begin
            err_d = 1'b1;
         end
         default: begin
            step_d = 1'b1;
            // Forward order moves B when A==B and moves A when A!=B.
            up_d   = (filt_q[1] ^ filt_q[0]) ? diff[1] : diff[0];
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         filt_q <= '0;
         cnt_q  <= '0;
         step_q <= 1'b0;
         up_q   <= UP_RST;
         err_q  <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
         step_q <= step_d;
         up_q   <= up_d;
         err_q  <= err_d;
      end
   end

   assign step = step_q;
   assign up   = up_q;
   assign err  = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: table-driven pin sequences with a scoreboard of
// expected step/up/err values at the edge each change should take effect.
module tb_quad_step_decoder;

   localparam int unsigned FILT_LEN = 3;
   localparam int          LAT      = FILT_LEN + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_in = 1'b0;
   logic b_in = 1'b0;
   logic err_clr = 1'b0;
   logic step, up, err;

   quad_step_decoder #(
      .FILT_LEN(FILT_LEN),
      .UP_RST  (1'b1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .a_in   (a_in),
      .b_in   (b_in),
      .err_clr(err_clr),
      .step   (step),
      .up     (up),
      .err    (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic  a;
      logic  b;
      int    hold;
      logic  exp_step;
      logic  exp_up;
      logic  exp_err;
      string nm;
   } vec_t;

   typedef struct {
      int    edge_no;
      logic  step;
      logic  up;
      logic  err;
      string nm;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic cmp(input string nm, input logic act, input logic exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp_v, cyc);
      end
   endtask

   task automatic check_cycle();
      exp_t e;
      while (sb_q.size() != 0 && sb_q[0].edge_no < cyc) begin
         e = sb_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: expectation for cycle %0d never evaluated, now %0d",
                  e.nm, e.edge_no, cyc);
      end
      if (sb_q.size() != 0 && sb_q[0].edge_no == cyc) begin
         e = sb_q.pop_front();
         cmp({e.nm, " step"}, step, e.step);
         cmp({e.nm, " up"}, up, e.up);
         cmp({e.nm, " err"}, err, e.err);
      end else begin
         cmp("idle step", step, 1'b0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_cycle();
   endtask

   task automatic expect_at(input int dly, input logic s, input logic u, input logic e,
                            input string nm);
      exp_t x;
      x.edge_no = cyc + dly;
      x.step    = s;
      x.up      = u;
      x.err     = e;
      x.nm      = nm;
      sb_q.push_back(x);
   endtask

   task automatic add_vec(input logic a, input logic b, input int hold, input logic s,
                          input logic u, input logic e, input string nm);
      vec_t v;
      v.a = a; v.b = b; v.hold = hold;
      v.exp_step = s; v.exp_up = u; v.exp_err = e; v.nm = nm;
      vecs.push_back(v);
   endtask

   initial begin
      // Forward Gray sequence
      add_vec(1'b0, 1'b1, 8, 1'b1, 1'b1, 1'b0, "fwd 00-01");
      add_vec(1'b1, 1'b1, 8, 1'b1, 1'b1, 1'b0, "fwd 01-11");
      add_vec(1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b0, "fwd 11-10");
      add_vec(1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0, "fwd 10-00");
      // Reverse Gray sequence
      add_vec(1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b0, "rev 00-10");
      add_vec(1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0, "rev 10-11");
      add_vec(1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0, "rev 11-01");
      add_vec(1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0, "rev 01-00");
      // Glitches: 2 cycles rejected, 3 cycles accepted
      add_vec(1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, "glitch2 rise");
      add_vec(1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, "glitch2 fall");
      add_vec(1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, "pulse3 rise");
      add_vec(1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0, "pulse3 fall");
      // A and B one cycle apart: back-to-back steps
      add_vec(1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, "skew 00-01");
      add_vec(1'b1, 1'b1, 8, 1'b1, 1'b1, 1'b0, "skew 01-11");
      add_vec(1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, "skew 11-10");
      add_vec(1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0, "skew 10-00");

      tick();
      cmp("reset step", step, 1'b0);
      cmp("reset up", up, 1'b1);
      cmp("reset err", err, 1'b0);
      tick();
      rst = 1'b0;

      // Idle after reset release
      for (int i = 0; i < 20; i++) begin
         tick();
         cmp("idle up", up, 1'b1);
         cmp("idle err", err, 1'b0);
      end

      foreach (vecs[i]) begin
         a_in = vecs[i].a;
         b_in = vecs[i].b;
         expect_at(LAT, vecs[i].exp_step, vecs[i].exp_up, vecs[i].exp_err, vecs[i].nm);
         repeat (vecs[i].hold) tick();
      end

      // Illegal 00->11, then clear
      a_in = 1'b1; b_in = 1'b1;
      expect_at(LAT, 1'b0, 1'b1, 1'b1, "illegal 00-11");
      repeat (8) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      cmp("err_clr clears", err, 1'b0);
      cmp("illegal up hold", up, 1'b1);

      // Illegal 11->00 with err_clr on the same edge: set wins
      a_in = 1'b0; b_in = 1'b0;
      expect_at(LAT, 1'b0, 1'b1, 1'b1, "illegal+clr 11-00");
      repeat (LAT - 1) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      repeat (3) tick();
      cmp("set wins held", err, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      cmp("err cleared again", err, 1'b0);

      // Get up=0, then reset asynchronously with a count in progress
      a_in = 1'b1;
      expect_at(LAT, 1'b1, 1'b0, 1'b0, "pre-reset rev 00-10");
      repeat (8) tick();
      a_in = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      cmp("async rst step", step, 1'b0);
      cmp("async rst up", up, 1'b1);
      cmp("async rst err", err, 1'b0);
      tick();
      rst = 1'b0;
      repeat (10) tick();
      cmp("post rst up", up, 1'b1);

      // Reset mid-filter with a_in held high through release
      a_in = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      cmp("mid rst err", err, 1'b0);
      rst = 1'b0;
      expect_at(LAT, 1'b1, 1'b0, 1'b0, "after rst 00-10");
      repeat (10) tick();

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
